// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM states, grant codes and AXI response codes.
// Build option ARB_ROUND_ROBIN_EN is consumed only by arb_grant_sel.
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_RD0_A = 3'd1,
      ARB_RD0_R = 3'd2,
      ARB_RD1_A = 3'd3,
      ARB_RD1_R = 3'd4,
      ARB_WR_AW = 3'd5,
      ARB_WR_B  = 3'd6
   } arb_state_t;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_RD0  = 2'd1,
      GRANT_RD1  = 2'd2,
      GRANT_WR   = 2'd3
   } grant_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // last_grant encoding: which read master was served most recently
   localparam logic LAST_M0 = 1'b0;
   localparam logic LAST_M1 = 1'b1;

   function automatic arb_state_t grant_to_state(input grant_t g);
      case (g)
         GRANT_RD0: return ARB_RD0_A;
         GRANT_RD1: return ARB_RD1_A;
         GRANT_WR:  return ARB_WR_AW;
         default:   return ARB_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Combinational grant picker: m1 write always wins; reads use fixed m1 priority or,
// with ARB_ROUND_ROBIN_EN defined, alternate between m0 and m1 when both pend.
module arb_grant_sel
   import mem_bus_arbiter_pkg::*;
(
   input  logic   rq0,
   input  logic   rq1r,
   input  logic   rq1w,
   input  logic   last_grant,
   output grant_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant = GRANT_NONE;
      if (rq1w)
         grant = GRANT_WR;
      else if (rq0 && rq1r)
         grant = (last_grant == LAST_M1) ? GRANT_RD0 : GRANT_RD1;
      else if (rq1r)
         grant = GRANT_RD1;
      else if (rq0)
         grant = GRANT_RD0;
   end
`else
   // Fixed priority has no use for history; the tie-off keeps the port uniform.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = GRANT_NONE;
      if (rq1w)
         grant = GRANT_WR;
      else if (rq1r)
         grant = GRANT_RD1;
      else if (rq0)
         grant = GRANT_RD0;
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master AXI-lite arbiter (IFU read-only, EXU read/write) onto one slave port,
// one transaction in flight. Read arbitration mode selected by ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic                  clock,
   input  logic                  reset,
   // m0: IFU read
   input  logic [ADDR_W-1:0]     m0_araddr,
   input  logic [2:0]            m0_arsize,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   // m1: EXU read/write
   input  logic [ADDR_W-1:0]     m1_araddr,
   input  logic [2:0]            m1_arsize,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   input  logic [ADDR_W-1:0]     m1_awaddr,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   output logic [1:0]            m1_bresp,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,
   // slave
   output logic [ADDR_W-1:0]     s_araddr,
   output logic [2:0]            s_arsize,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic [ADDR_W-1:0]     s_awaddr,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready
);

   arb_state_t state_reg, state_next;
   logic       aw_done_reg, aw_done_next;
   logic       w_done_reg, w_done_next;
   logic       last_grant_reg, last_grant_next;
   grant_t     grant;
   logic       wr_both_ok;

   arb_grant_sel u_grant_sel (
      .rq0        (m0_arvalid),
      .rq1r       (m1_arvalid),
      .rq1w       (m1_awvalid && m1_wvalid),
      .last_grant (last_grant_reg),
      .grant      (grant)
   );

   // Both halves of the write are accepted towards the EXU in the same cycle.
   assign wr_both_ok = (aw_done_reg || s_awready) && (w_done_reg || s_wready);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ARB_IDLE;
         aw_done_reg    <= 1'b0;
         w_done_reg     <= 1'b0;
         last_grant_reg <= LAST_M1;
      end else begin
         state_reg      <= state_next;
         aw_done_reg    <= aw_done_next;
         w_done_reg     <= w_done_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      aw_done_next    = aw_done_reg;
      w_done_next     = w_done_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         ARB_IDLE: begin
            state_next = grant_to_state(grant);
            if (grant == GRANT_RD0) last_grant_next = LAST_M0;
            if (grant == GRANT_RD1) last_grant_next = LAST_M1;
         end
         ARB_RD0_A: if (s_arvalid && s_arready) state_next = ARB_RD0_R;
         ARB_RD0_R: if (s_rvalid && s_rready)   state_next = ARB_IDLE;
         ARB_RD1_A: if (s_arvalid && s_arready) state_next = ARB_RD1_R;
         ARB_RD1_R: if (s_rvalid && s_rready)   state_next = ARB_IDLE;
         ARB_WR_AW: begin
            if (wr_both_ok) begin
               state_next   = ARB_WR_B;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
            end else begin
               aw_done_next = aw_done_reg || (s_awvalid && s_awready);
               w_done_next  = w_done_reg  || (s_wvalid && s_wready);
            end
         end
         ARB_WR_B: if (s_bvalid && s_bready) state_next = ARB_IDLE;
         default: state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      m0_arready = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bresp   = '0;
      m1_bvalid  = 1'b0;
      s_araddr   = '0;
      s_arsize   = '0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awaddr   = '0;
      s_awvalid  = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (state_reg)
         ARB_RD0_A: begin
            s_araddr   = m0_araddr;
            s_arsize   = m0_arsize;
            s_arvalid  = m0_arvalid;
            m0_arready = s_arready;
         end
         ARB_RD0_R: begin
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            m0_rvalid = s_rvalid;
            s_rready  = m0_rready;
         end
         ARB_RD1_A: begin
            s_araddr   = m1_araddr;
            s_arsize   = m1_arsize;
            s_arvalid  = m1_arvalid;
            m1_arready = s_arready;
         end
         ARB_RD1_R: begin
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            m1_rvalid = s_rvalid;
            s_rready  = m1_rready;
         end
         ARB_WR_AW: begin
            s_awaddr   = m1_awaddr;
            s_awvalid  = m1_awvalid && !aw_done_reg;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wvalid   = m1_wvalid && !w_done_reg;
            m1_awready = wr_both_ok;
            m1_wready  = wr_both_ok;
         end
         ARB_WR_B: begin
            m1_bresp  = s_bresp;
            m1_bvalid = s_bvalid;
            s_bready  = m1_bready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: manual slave responses, scoreboard of expected
// R/B beats checked at each master-side handshake.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
   logic [2:0]  m0_arsize, m1_arsize;
   logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
   logic        m1_awvalid, m1_wvalid, m1_bready;
   logic [3:0]  m1_wstrb;
   logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [1:0]  s_rresp, s_bresp;
   logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
   logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
   logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
   logic [2:0]  s_arsize;
   logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [3:0]  s_wstrb;

   typedef struct {
      int          src;   // 0: m0 R, 1: m1 R, 2: m1 B
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;
   exp_t sb_q[$];

   int vectors = 0;
   int miscompares = 0;
   int aw_hs = 0;
   int w_hs = 0;

   always #5 clock = ~clock;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   always @(posedge clock) begin
      if (!reset && s_awvalid && s_awready) aw_hs++;
      if (!reset && s_wvalid && s_wready)   w_hs++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input int src, input logic [31:0] data, input logic [1:0] resp);
      exp_t e;
      chk("sb_expected_beat", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("sb_src", 64'(src), 64'(e.src));
         chk("sb_data", 64'(data), 64'(e.data));
         chk("sb_resp", 64'(resp), 64'(e.resp));
      end
   endtask

   // Settle combinational outputs, then score any master-side R/B handshake.
   task automatic settle();
      #1;
      if (m0_rvalid && m0_rready) sb_pop(0, m0_rdata, m0_rresp);
      if (m1_rvalid && m1_rready) sb_pop(1, m1_rdata, m1_rresp);
      if (m1_bvalid && m1_bready) sb_pop(2, 32'h0, m1_bresp);
   endtask

   function automatic logic [11:0] ctl_bits();
      return {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready,
              m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
   endfunction

   function automatic logic arready_of(input int m);
      return (m == 0) ? m0_arready : m1_arready;
   endfunction

   task automatic drive_ar(input int m, input logic v, input logic [31:0] a);
      if (m == 0) begin m0_arvalid = v; m0_araddr = a; m0_arsize = 3'd2; end
      else        begin m1_arvalid = v; m1_araddr = a; m1_arsize = 3'd2; end
   endtask

   task automatic set_rready(input int m, input logic v);
      if (m == 0) m0_rready = v; else m1_rready = v;
   endtask

   task automatic rd_req(input int m, input logic [31:0] a);
      @(negedge clock);
      drive_ar(m, 1'b1, a);
      set_rready(m, 1'b1);
      settle();
      chk("ar_bubble", 64'(s_arvalid), 64'd0);
   endtask

   // From the address-phase cycle to the IDLE cycle after the R handshake.
   task automatic rd_finish(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      @(negedge clock);
      s_arready = 1'b1;
      settle();
      chk("ar_valid", 64'(s_arvalid), 64'd1);
      chk("ar_addr", 64'(s_araddr), 64'(a));
      chk("ar_ready_gnt", 64'(arready_of(m)), 64'd1);
      chk("ar_ready_other", 64'(arready_of(1 - m)), 64'd0);
      @(negedge clock);
      drive_ar(m, 1'b0, 32'h0);
      s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = d; s_rresp = r;
      sb_q.push_back('{m, d, r});
      settle();
      chk("r_rready", 64'(s_rready), 64'd1);
      chk("r_other_rvalid", 64'((m == 0) ? m1_rvalid : m0_rvalid), 64'd0);
      @(negedge clock);
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      set_rready(m, 1'b0);
      settle();
      chk("r_idle", 64'(ctl_bits()), 64'd0);
   endtask

   initial begin
      int first_m, second_m, aw0, w0;
      reset = 1'b1;
      m0_araddr = '0; m0_arsize = '0; m0_arvalid = 0; m0_rready = 0;
      m1_araddr = '0; m1_arsize = '0; m1_arvalid = 0; m1_rready = 0;
      m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
      s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
      s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;

      // Reset state
      @(negedge clock); @(negedge clock);
      settle();
      chk("reset_ctl", 64'(ctl_bits()), 64'd0);
      chk("reset_araddr", 64'(s_araddr), 64'd0);
      reset = 1'b0;

      // Simultaneous reads straight after reset
`ifdef ARB_ROUND_ROBIN_EN
      first_m = 0; second_m = 1;
`else
      first_m = 1; second_m = 0;
`endif
      @(negedge clock);
      drive_ar(0, 1'b1, 32'h8000_0010); m0_rready = 1'b1;
      drive_ar(1, 1'b1, 32'h2000_0020); m1_rready = 1'b1;
      settle();
      chk("tie_bubble", 64'(s_arvalid), 64'd0);
      rd_finish(first_m, (first_m == 0) ? 32'h8000_0010 : 32'h2000_0020, 32'h1111_0001, RESP_OKAY);
      rd_finish(second_m, (second_m == 0) ? 32'h8000_0010 : 32'h2000_0020, 32'h2222_0002, RESP_OKAY);

      // Plain m0 fetch
      rd_req(0, 32'h8000_0000);
      rd_finish(0, 32'h8000_0000, 32'h0000_0413, RESP_OKAY);

      // m1 byte store, slave AW accepted one cycle before W
      aw0 = aw_hs; w0 = w_hs;
      @(negedge clock);
      m1_awvalid = 1'b1; m1_awaddr = 32'ha000_03f8;
      m1_wvalid = 1'b1; m1_wdata = 32'h0000_005a; m1_wstrb = 4'b0001; m1_bready = 1'b1;
      settle();
      chk("wr_bubble", 64'(s_awvalid), 64'd0);
      @(negedge clock);
      s_awready = 1'b1;
      settle();
      chk("wr_aw_valid", 64'({s_awvalid, s_wvalid}), 64'b11);
      chk("wr_addr", 64'(s_awaddr), 64'ha000_03f8);
      chk("wr_strb", 64'(s_wstrb), 64'h1);
      chk("wr_hold_ready", 64'({m1_awready, m1_wready}), 64'b00);
      @(negedge clock);
      s_awready = 1'b0; s_wready = 1'b1;
      settle();
      chk("wr_aw_dropped", 64'({s_awvalid, s_wvalid}), 64'b01);
      chk("wr_accept", 64'({m1_awready, m1_wready}), 64'b11);
      @(negedge clock);
      m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_wready = 1'b0;
      s_bvalid = 1'b1; s_bresp = RESP_OKAY;
      sb_q.push_back('{2, 32'h0, RESP_OKAY});
      settle();
      chk("wr_b_ready", 64'({s_bready, m1_awready, m1_wready}), 64'b100);
      @(negedge clock);
      s_bvalid = 1'b0; m1_bready = 1'b0;
      settle();
      chk("wr_idle", 64'(ctl_bits()), 64'd0);
      chk("wr_aw_hs_count", 64'(aw_hs - aw0), 64'd1);
      chk("wr_w_hs_count", 64'(w_hs - w0), 64'd1);

      // SLVERR passes through, then m0 is served
      rd_req(1, 32'h1000_0000);
      rd_finish(1, 32'h1000_0000, 32'hdead_beef, RESP_SLVERR);
      rd_req(0, 32'h8000_0004);
      rd_finish(0, 32'h8000_0004, 32'h0010_0093, RESP_OKAY);

      // Reset while in RD0_R with rvalid pending
      rd_req(0, 32'h8000_0008);
      @(negedge clock);
      s_arready = 1'b1;
      settle();
      chk("rst_ar_valid", 64'(s_arvalid), 64'd1);
      @(negedge clock);
      drive_ar(0, 1'b0, 32'h0); s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'hbad0_bad0; m0_rready = 1'b0; reset = 1'b1;
      settle();
      chk("rst_rvalid_before", 64'(m0_rvalid), 64'd1);
      @(negedge clock);
      reset = 1'b0;
      settle();
      chk("rst_all_zero", 64'(ctl_bits()), 64'd0);
      chk("rst_rdata_zero", 64'(m0_rdata), 64'd0);
      @(negedge clock);
      s_rvalid = 1'b0; s_rdata = '0;
      settle();
      rd_req(0, 32'h8000_000c);
      rd_finish(0, 32'h8000_000c, 32'h0000_0513, RESP_OKAY);

      // m1 stalls R for 5 cycles while m0 waits
      rd_req(1, 32'h1000_0100);
      m1_rready = 1'b0;
      @(negedge clock);
      s_arready = 1'b1;
      settle();
      chk("stall_ar_addr", 64'(s_araddr), 64'h1000_0100);
      @(negedge clock);
      drive_ar(1, 1'b0, 32'h0); s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'hcafe_0006; s_rresp = RESP_OKAY;
      drive_ar(0, 1'b1, 32'h8000_0100); m0_rready = 1'b1;
      sb_q.push_back('{1, 32'hcafe_0006, RESP_OKAY});
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clock);
         settle();
         chk("stall_ctl", 64'({s_rready, m0_arready, s_arvalid, m1_rvalid}), 64'b0001);
      end
      @(negedge clock);
      m1_rready = 1'b1;
      settle();
      chk("stall_release", 64'(s_rready), 64'd1);
      @(negedge clock);
      s_rvalid = 1'b0; s_rdata = '0; m1_rready = 1'b0;
      settle();
      chk("stall_idle", 64'({m0_arready, s_arvalid}), 64'd0);
      rd_finish(0, 32'h8000_0100, 32'h0000_0613, RESP_OKAY);

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
